// File: rtl/sram_node_reader.sv
// sram_node_reader
//   Streams a burst of consecutive SRAM words out through a valid/ready port,
//   splitting each 34-bit word into hi/mid/lo/payload fields. Reads are issued
//   only while the 2-entry output FIFO plus the read in flight has room, so a
//   stalled consumer never causes a word to be dropped.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             command strobe (only honoured in IDLE)
//   i_base_addr         first SRAM address of the burst
//   i_count             entries to read, 0..2^ADDR_WIDTH
//   o_busy, o_done      burst in progress / one-cycle completion pulse
//   o_mem_addr          SRAM address (read data returns one cycle later)
//   o_mem_write         SRAM write enable, tied low
//   i_mem_data          SRAM read data
//   o_valid, i_ready    output handshake
//   o_hi/o_mid/o_lo     word bits [33:26]/[25:18]/[17:10]
//   o_payload           word bits [9:0]
//   o_addr              SRAM address the head entry came from
//   o_last              head entry is the final one of the burst
module sram_node_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 34
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_write,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_hi,
    output logic [7:0]            o_mid,
    output logic [7:0]            o_lo,
    output logic [9:0]            o_payload,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] rd_addr;      // next address to issue
    logic [ADDR_WIDTH:0]   remaining;    // reads still to issue
    logic [ADDR_WIDTH-1:0] mem_addr_q;   // last issued address, held when idle

    // Read in flight: data appears on i_mem_data the cycle after issue.
    logic                  fl_vld;
    logic [ADDR_WIDTH-1:0] fl_addr;
    logic                  fl_last;

    entry_t                fifo [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fill;

    entry_t                head;
    logic                  pop;
    logic                  issue;
    logic [2:0]            occ;

    assign head    = fifo[rd_ptr];
    assign o_valid = (fill != 2'd0);
    assign pop     = o_valid && i_ready;

    // Occupancy credits the entry leaving this cycle; without that credit a
    // full-rate stream would stall every other cycle.
    assign occ   = 3'(fill) + 3'(fl_vld) - 3'(pop);
    assign issue = (state == READ) && (occ < 3'd2);

    assign o_mem_addr  = issue ? rd_addr : mem_addr_q;
    assign o_mem_write = 1'b0;

    assign o_hi      = head.data[33:26];
    assign o_mid     = head.data[25:18];
    assign o_lo      = head.data[17:10];
    assign o_payload = head.data[9:0];
    assign o_addr    = head.addr;
    assign o_last    = o_valid && head.last;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            rd_addr    <= '0;
            remaining  <= '0;
            mem_addr_q <= '0;
            fl_vld     <= 1'b0;
            fl_addr    <= '0;
            fl_last    <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fill       <= 2'd0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            for (int i = 0; i < 2; i++) fifo[i] <= '0;
        end else begin
            o_done <= 1'b0;

            if (issue) begin
                mem_addr_q <= rd_addr;
                rd_addr    <= rd_addr + ADDR_WIDTH'(1);
                remaining  <= remaining - (ADDR_WIDTH+1)'(1);
                fl_addr    <= rd_addr;
                fl_last    <= (remaining == (ADDR_WIDTH+1)'(1));
            end
            fl_vld <= issue;

            // Capture the word returned for last cycle's issue.
            if (fl_vld) begin
                fifo[wr_ptr] <= '{addr: fl_addr, last: fl_last, data: i_mem_data};
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            fill <= fill + 2'(fl_vld) - 2'(pop);

            case (state)
                IDLE: begin
                    if (i_start) begin
                        rd_addr   <= i_base_addr;
                        remaining <= i_count;
                        if (i_count == '0) begin
                            o_done <= 1'b1;
                        end else begin
                            state  <= READ;
                            o_busy <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && remaining == (ADDR_WIDTH+1)'(1)) state <= DRAIN;
                end
                DRAIN: begin
                    // The last-flagged entry is always the final one buffered
                    // and nothing is in flight behind it.
                    if (pop && head.last) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
